// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the IF/ID hazard controller:
//   state_t : controller FSM states (RUN, LOAD_STALL, FLUSH, MEM_WAIT)
//   REG_W   : default register address width
//   X0      : index of the hard-wired zero register, which never creates a
//             data dependence
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int REG_W = 5;
  localparam int X0    = 0;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    MEM_WAIT   = 2'd3
  } state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use compare between the load in EX and the
// source registers of the instruction held in IF/ID.
// Ports:
//   id_r1, id_r2  in  source registers held in IF/ID
//   id_uses_r2    in  instruction in ID actually reads r2
//   ex_rd         in  destination register of the instruction in EX
//   ex_is_load    in  instruction in EX is a load
//   hazard        out load-use dependence detected this cycle
// ---------------------------------------------------------------------------
module hazard_detect #(
  parameter int REG_W = pipe_pkg::REG_W
) (
  input  logic [REG_W-1:0] id_r1,
  input  logic [REG_W-1:0] id_r2,
  input  logic             id_uses_r2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  output logic             hazard
);
  import pipe_pkg::*;

  logic rd_valid;
  logic match_r1;
  logic match_r2;

  // Writes to the zero register are discarded, so they can never be a
  // producer; r2 only matters when the consumer actually reads it.
  assign rd_valid = ex_rd != REG_W'(X0);
  assign match_r1 = ex_rd == id_r1;
  assign match_r2 = id_uses_r2 && (ex_rd == id_r2);
  assign hazard   = ex_is_load && rd_valid && (match_r1 || match_r2);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Control-side companion of the IF/ID register: resolves load-use stalls,
// taken-branch flushes and data-memory waits. Outputs are Mealy, so a hazard
// acts in the cycle it is detected.
// Optional feature: define HAZARD_STATS_EN to add the saturating
// stall_count[15:0] output counting cycles with stall_active high.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   id_r1, id_r2        source registers held in IF/ID
//   id_uses_r2          instruction in ID reads r2
//   ex_rd, ex_is_load   destination / load flag of the instruction in EX
//   branch_taken        EX resolved a taken branch this cycle
//   mem_busy            data memory still busy
//   pc_en               PC update enable
//   if_id_en            IF/ID enable
//   if_id_flush         IF/ID clear
//   id_ex_flush         ID/EX clear (bubble)
//   ex_mem_en           EX/MEM and later stage enable
//   stall_active        high whenever pc_en is low
//   stall_count         (HAZARD_STATS_EN only) saturating stall cycle count
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int REG_W             = pipe_pkg::REG_W,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_r1,
  input  logic [REG_W-1:0] id_r2,
  input  logic             id_uses_r2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             stall_active
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]      stall_count
`endif
);
  import pipe_pkg::*;

  // The cycle that detects an event is itself the first bubble/flush cycle,
  // so the counter is loaded with the number of extra cycles minus one.
  localparam bit         LOAD_MULTI   = LOAD_STALL_CYCLES > 1;
  localparam bit         FLUSH_MULTI  = FLUSH_CYCLES > 1;
  localparam logic [3:0] LOAD_RELOAD  = LOAD_MULTI  ? 4'(LOAD_STALL_CYCLES - 2) : 4'd0;
  localparam logic [3:0] FLUSH_RELOAD = FLUSH_MULTI ? 4'(FLUSH_CYCLES - 2)      : 4'd0;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       hazard;
  logic       do_branch;
  logic       do_mem;
  logic       do_hazard;

  hazard_detect #(
    .REG_W (REG_W)
  ) u_hazard_detect (
    .id_r1      (id_r1),
    .id_r2      (id_r2),
    .id_uses_r2 (id_uses_r2),
    .ex_rd      (ex_rd),
    .ex_is_load (ex_is_load),
    .hazard     (hazard)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    do_branch    = 1'b0;
    do_mem       = 1'b0;
    do_hazard    = 1'b0;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b1;

    // Event selection. Only RUN and MEM_WAIT look at mem_busy and hazard;
    // the timed states run to completion unless a new branch arrives.
    case (state)
      LOAD_STALL: begin
        if (branch_taken) begin
          do_branch = 1'b1;
        end else begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
          if (cnt == 4'd0) state_nxt = RUN;
          else             cnt_nxt   = cnt - 4'd1;
        end
      end
      FLUSH: begin
        if (branch_taken) begin
          do_branch = 1'b1;
        end else begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          if (cnt == 4'd0) state_nxt = RUN;
          else             cnt_nxt   = cnt - 4'd1;
        end
      end
      default: begin
        // MEM_WAIT with memory idle behaves exactly like RUN; while memory
        // is still busy a branch cannot be honoured because nothing moves.
        if (branch_taken && !(state == MEM_WAIT && mem_busy)) do_branch = 1'b1;
        else if (mem_busy)                                     do_mem    = 1'b1;
        else if (hazard)                                       do_hazard = 1'b1;
        else                                                   state_nxt = RUN;
      end
    endcase

    if (do_branch) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      pc_en       = 1'b1;
      state_nxt   = FLUSH_MULTI ? FLUSH : RUN;
      cnt_nxt     = FLUSH_RELOAD;
    end else if (do_mem) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      ex_mem_en = 1'b0;
      state_nxt = MEM_WAIT;
    end else if (do_hazard) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
      state_nxt   = LOAD_MULTI ? LOAD_STALL : RUN;
      cnt_nxt     = LOAD_RELOAD;
    end

    // Reset freezes the front end and bubbles both registers immediately,
    // without waiting for the state register to clear.
    if (!rst) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      ex_mem_en   = 1'b0;
    end

    stall_active = ~pc_en;
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_count <= 16'd0;
    end else if (stall_active && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Drives two controller instances (short and long stall/flush settings) from
// shared inputs and compares every output against a cycle-count model that
// tracks remaining flush/stall cycles directly.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int L0 = 1;
  localparam int F0 = 2;
  localparam int L1 = 4;
  localparam int F1 = 3;

  // Output vector order: {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, stall_active}
  localparam logic [5:0] O_RESET = 6'b001101;
  localparam logic [5:0] O_RUN   = 6'b110010;
  localparam logic [5:0] O_FLUSH = 6'b111110;
  localparam logic [5:0] O_STALL = 6'b000111;
  localparam logic [5:0] O_HOLD  = 6'b000001;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [REG_W-1:0] id_r1 = '0;
  logic [REG_W-1:0] id_r2 = '0;
  logic             id_uses_r2 = 1'b0;
  logic [REG_W-1:0] ex_rd = '0;
  logic             ex_is_load = 1'b0;
  logic             branch_taken = 1'b0;
  logic             mem_busy = 1'b0;

  logic pc0, ifen0, iff0, idf0, exm0, st0;
  logic pc1, ifen1, iff1, idf1, exm1, st1;
  logic [5:0] outs [2];
`ifdef HAZARD_STATS_EN
  logic [15:0] stats [2];
`endif

  int checkCount = 0;
  int failCount  = 0;

  int flushLeft [2];
  int stallLeft [2];
  bit waiting   [2];
  int statCount [2];
  int loadCyc   [2];
  int flushCyc  [2];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .REG_W (REG_W), .LOAD_STALL_CYCLES (L0), .FLUSH_CYCLES (F0)
  ) dut0 (
    .clk (clk), .rst (rst), .id_r1 (id_r1), .id_r2 (id_r2),
    .id_uses_r2 (id_uses_r2), .ex_rd (ex_rd), .ex_is_load (ex_is_load),
    .branch_taken (branch_taken), .mem_busy (mem_busy),
    .pc_en (pc0), .if_id_en (ifen0), .if_id_flush (iff0),
    .id_ex_flush (idf0), .ex_mem_en (exm0), .stall_active (st0)
`ifdef HAZARD_STATS_EN
    , .stall_count (stats[0])
`endif
  );

  pipeline_hazard_ctrl #(
    .REG_W (REG_W), .LOAD_STALL_CYCLES (L1), .FLUSH_CYCLES (F1)
  ) dut1 (
    .clk (clk), .rst (rst), .id_r1 (id_r1), .id_r2 (id_r2),
    .id_uses_r2 (id_uses_r2), .ex_rd (ex_rd), .ex_is_load (ex_is_load),
    .branch_taken (branch_taken), .mem_busy (mem_busy),
    .pc_en (pc1), .if_id_en (ifen1), .if_id_flush (iff1),
    .id_ex_flush (idf1), .ex_mem_en (exm1), .stall_active (st1)
`ifdef HAZARD_STATS_EN
    , .stall_count (stats[1])
`endif
  );

  assign outs[0] = {pc0, ifen0, iff0, idf0, exm0, st0};
  assign outs[1] = {pc1, ifen1, iff1, idf1, exm1, st1};

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Reference: remaining forced cycles are plain integers; expected outputs
  // follow the event priority of the controller description.
  task automatic modelStep(input int k, output logic [5:0] expOut);
    bit hz;
    hz = ex_is_load && (ex_rd != 0) &&
         ((ex_rd == id_r1) || (id_uses_r2 && (ex_rd == id_r2)));
    if (!rst) begin
      expOut = O_RESET;
      flushLeft[k] = 0; stallLeft[k] = 0; waiting[k] = 0;
    end else if (branch_taken && !(waiting[k] && mem_busy)) begin
      expOut = O_FLUSH;
      flushLeft[k] = flushCyc[k] - 1; stallLeft[k] = 0; waiting[k] = 0;
    end else if (flushLeft[k] > 0) begin
      expOut = O_FLUSH;
      flushLeft[k]--;
    end else if (stallLeft[k] > 0) begin
      expOut = O_STALL;
      stallLeft[k]--;
    end else if (mem_busy) begin
      expOut = O_HOLD;
      waiting[k] = 1;
    end else if (hz) begin
      expOut = O_STALL;
      stallLeft[k] = loadCyc[k] - 1; waiting[k] = 0;
    end else begin
      expOut = O_RUN;
      waiting[k] = 0;
    end
  endtask

  task automatic stepCycle(input string tag);
    logic [5:0] expOut;
    for (int k = 0; k < 2; k++) begin
`ifdef HAZARD_STATS_EN
      checkOutput($sformatf("%s.d%0d.count", tag, k), stats[k], 16'(statCount[k]));
`endif
      modelStep(k, expOut);
      checkOutput($sformatf("%s.d%0d", tag, k), 16'(outs[k]), 16'(expOut));
      if (!rst) statCount[k] = 0;
      else if (expOut[0] && statCount[k] < 65535) statCount[k]++;
    end
  endtask

  // Called at a falling edge: drive inputs, sample just after, advance.
  task automatic applyStimulus(input logic r, input int r1, input int r2, input logic u,
                               input int rd, input logic ld, input logic br,
                               input logic busy, input string tag);
    rst          = r;
    id_r1        = REG_W'(r1);
    id_r2        = REG_W'(r2);
    id_uses_r2   = u;
    ex_rd        = REG_W'(rd);
    ex_is_load   = ld;
    branch_taken = br;
    mem_busy     = busy;
    #1;
    stepCycle(tag);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(1, 1, 2, 1, 3, 0, 0, 0, tag);
  endtask

  initial begin
    loadCyc  = '{L0, L1};
    flushCyc = '{F0, F1};
    for (int k = 0; k < 2; k++) begin
      flushLeft[k] = 0; stallLeft[k] = 0; waiting[k] = 0; statCount[k] = 0;
    end
    @(negedge clk);

    $display("[TB] reset");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, "reset");
    applyStimulus(0, 5, 5, 1, 5, 1, 1, 1, "reset_events");
    checkOutput("reset_const", 16'(outs[0]), 16'(O_RESET));
    idle(2, "after_reset");

    $display("[TB] load-use");
    applyStimulus(1, 5, 7, 0, 5, 1, 0, 0, "load_use");
    idle(4, "load_use_after");
    applyStimulus(1, 9, 6, 1, 6, 1, 0, 0, "load_use_r2");
    applyStimulus(1, 9, 6, 0, 6, 1, 0, 0, "r2_unused");
    idle(3, "r2_after");

    $display("[TB] x0 immunity");
    applyStimulus(1, 0, 0, 1, 0, 1, 0, 0, "x0");
    checkOutput("x0_stall_active", 16'(st0), 16'd0);

    $display("[TB] branch");
    applyStimulus(1, 1, 2, 0, 3, 0, 1, 0, "branch");
    idle(3, "branch_after");
    applyStimulus(1, 1, 2, 0, 3, 0, 1, 0, "branch_a");
    applyStimulus(1, 1, 2, 0, 3, 0, 1, 0, "branch_reload");
    idle(4, "reload_after");

    $display("[TB] simultaneous branch and hazard");
    applyStimulus(1, 5, 5, 1, 5, 1, 1, 0, "br_hz");
    idle(4, "br_hz_after");

    $display("[TB] memory wait");
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 2, 0, 3, 0, 0, 1, "mem_busy");
    idle(1, "mem_release");
    applyStimulus(1, 4, 2, 0, 4, 1, 1, 1, "mem_br_busy");
    applyStimulus(1, 4, 2, 0, 4, 1, 1, 1, "mem_wait_br");
    applyStimulus(1, 4, 2, 0, 4, 1, 0, 0, "mem_exit_hz");
    idle(5, "mem_after");

    $display("[TB] reset mid-stall");
    applyStimulus(1, 8, 2, 0, 8, 1, 0, 0, "ms_hazard");
    applyStimulus(0, 1, 2, 0, 3, 0, 0, 0, "ms_reset");
    idle(3, "ms_after");
    checkOutput("ms_run_dut1", 16'(outs[1]), 16'(O_RUN));

    $display("[TB] random");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 39) != 0),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    ($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 4) == 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Control-side counterpart of the IF/ID pipeline register. It drives that register's enable and clear, plus the PC enable and the ID/EX bubble.
- Consumes the decoded source registers latched in IF/ID, the EX-stage destination and load flag, the branch-taken result, and the memory busy signal.
- Resolves load-use hazards, branch flushes and memory waits using a small FSM with a stall counter.

Parameters:
- REG_W, 5, register address width
- LOAD_STALL_CYCLES, 1, bubble cycles inserted per load-use hazard (1..15)
- FLUSH_CYCLES, 2, cycles IF/ID and ID/EX are held cleared after a taken branch (1..15)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-low reset
- id_r1  in  REG_W  source register 1 held in IF/ID
- id_r2  in  REG_W  source register 2 held in IF/ID
- id_uses_r2  in  1  instruction in ID reads r2
- ex_rd  in  REG_W  destination register of the instruction in EX
- ex_is_load  in  1  instruction in EX is a load
- branch_taken  in  1  EX resolved a taken branch/jump this cycle
- mem_busy  in  1  data memory has not completed the current access
- pc_en  out  1  PC update enable
- if_id_en  out  1  IF/ID register enable
- if_id_flush  out  1  IF/ID clear (bubble)
- id_ex_flush  out  1  ID/EX clear (bubble)
- ex_mem_en  out  1  EX/MEM and later stage enable
- stall_active  out  1  high whenever pc_en is low for any cause

Behaviour:
- Reset is synchronous. While rst=0 at a clk edge, state<=RUN and cnt<=0.
- Outputs during reset: pc_en=0, if_id_en=0, if_id_flush=1, id_ex_flush=1, ex_mem_en=0, stall_active=1.
- Outputs are combinational from state, cnt and the current inputs (Mealy). A hazard takes effect in the same cycle it is detected.
- hazard = ex_is_load & ex_rd!=0 & (ex_rd==id_r1 | (id_uses_r2 & ex_rd==id_r2)). Register 0 never causes a hazard.
- Priority when events coincide: branch_taken > mem_busy > hazard.
- State RUN:
  - No event: all enables 1, flushes 0.
  - branch_taken: if_id_flush=1, id_ex_flush=1, pc_en=1 (loads the target). If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-2.
  - mem_busy: pc_en, if_id_en and ex_mem_en are 0, flushes are 0; go to MEM_WAIT.
  - hazard: pc_en=0, if_id_en=0, id_ex_flush=1. If LOAD_STALL_CYCLES>1, go to LOAD_STALL with cnt=LOAD_STALL_CYCLES-2.
- State LOAD_STALL:
  - Same outputs as the hazard case.
  - cnt decrements each cycle; return to RUN when cnt==0.
  - branch_taken overrides: apply the RUN branch action and go to FLUSH.
- State FLUSH:
  - if_id_flush=1, id_ex_flush=1, pc_en=1.
  - cnt decrements; return to RUN when cnt==0.
  - A new branch_taken reloads cnt.
- State MEM_WAIT:
  - Holds all stages; no flushes.
  - Leaves for RUN in the first cycle mem_busy=0. That cycle is evaluated as RUN (Mealy), so a pending hazard is caught immediately.
  - branch_taken is ignored while mem_busy=1.
- cnt is 4 bits and never wraps; decrement occurs only when cnt>0.
- stall_active = ~pc_en.
- Reset asserted mid-stall aborts the stall with no residual bubble after release.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined: adds output stall_count [15:0], a saturating counter that increments every cycle stall_active=1 outside reset. It clears on reset and holds at 16'hFFFF.
- Undefined: the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg: state enum (RUN, LOAD_STALL, FLUSH, MEM_WAIT), REG_W, and the x0 register constant.
- One sub-module, hazard_detect: the purely combinational compare that produces hazard.
- The FSM and counter stay in the top module.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, id_r1=5, LOAD_STALL_CYCLES=1 -> one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; next cycle, with the load no longer in EX, all enables are 1.
- x0 immunity: ex_is_load=1, ex_rd=0, id_r1=0 -> no stall, stall_active=0.
- Branch: branch_taken=1 for one cycle, FLUSH_CYCLES=2 -> if_id_flush and id_ex_flush high for exactly 2 cycles, pc_en=1 throughout.
- Simultaneous events: branch_taken=1 and hazard in the same cycle -> branch action wins and no LOAD_STALL is entered.
- Memory wait: mem_busy=1 for 3 cycles -> pc_en, if_id_en and ex_mem_en low for 3 cycles; restored in the cycle mem_busy falls.
- Reset mid-stall: LOAD_STALL_CYCLES=4, rst=0 on the 2nd stall cycle -> reset output values; after release, RUN with all enables 1 (stall_count=0 when HAZARD_STATS_EN is defined).
